// File: rtl/riscv_lsu_pkg.sv
// Shared constants and types for the riscv_lsu load/store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store steering, byte enables and access legality,
// plus load byte/half extraction with sign or zero extension.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic        st_reject,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_reject     = 1'b0;
    st_be         = 4'hF;
    st_wdata_lane = st_wdata;
    case (st_funct3)
      F3_B: begin
        if (is_store) begin
          st_be         = 4'b0001 << st_addr_lo;
          st_wdata_lane = {4{st_wdata[7:0]}};
        end
      end
      F3_H: begin
        st_reject = st_addr_lo[0];
        if (is_store) begin
          st_be         = 4'b0011 << st_addr_lo;
          st_wdata_lane = {2{st_wdata[15:0]}};
        end
      end
      F3_W:    st_reject = |st_addr_lo;
      F3_BU:   st_reject = is_store;
      F3_HU:   st_reject = is_store | st_addr_lo[0];
      default: st_reject = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: IDLE -> REQ -> DONE handshake to a word-addressed bus.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              fault,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              st_reject;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata_lane;
  logic [31:0]       ld_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  lsu_align u_align (
    .is_store      (is_store),
    .st_funct3     (funct3),
    .st_addr_lo    (addr[1:0]),
    .st_wdata      (wdata),
    .st_reject     (st_reject),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .ld_funct3     (funct3_q),
    .ld_addr_lo    (lane_q),
    .ld_word       (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    stall     = 1'b0;
    fault     = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start & ~st_reject;
        fault = start & st_reject;
        if (start && !st_reject) begin
          state_d   = REQ;
          we_d      = is_store;
          addr_d    = {addr[ADDR_W-1:2], 2'b00};
          be_d      = st_be;
          wdata_d   = st_wdata_lane;
          funct3_d  = funct3;
          lane_d    = addr[1:0];
          rdata_d   = '0;
          bus_err_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          rdata_d = we_q ? 32'h0 : ld_data;
          state_d = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        // A ready arriving on the final counted cycle still completes normally.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      lane_q    <= lane_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rdata     = done ? rdata_q : 32'h0;
  assign bus_err   = done & bus_err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a transaction-level model predicts every
// cycle's outputs; a negedge process compares them against the DUT.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        done, stall, fault, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  riscv_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .fault(fault), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic        e_stall, e_fault, e_done, e_buserr, e_req, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the rules of the access, expressed directly from the ISA meaning.
  function automatic bit m_reject(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit bad_f3, mis;
    bad_f3 = st ? !(f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b011, 3'b110, 3'b111});
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    return bad_f3 || mis;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'hF;
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return 4'b0011 << a[1:0];
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_lane(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = 8 * int'(a[1:0]);
    b = word[sh +: 8];
    h = (sh <= 16) ? word[sh +: 16] : 16'h0;
    case (f3)
      F3_B:    return 32'($signed(b));
      F3_BU:   return {24'h0, b};
      F3_H:    return 32'($signed(h));
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  task automatic idle_exp();
    e_stall = 0; e_fault = 0; e_done = 0; e_buserr = 0; e_req = 0; e_we = 0;
    e_rdata = 0; e_addr = 0; e_wdata = 0; e_be = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'h0, stall}, {31'h0, e_stall});
      check("fault", {31'h0, fault}, {31'h0, e_fault});
      check("done", {31'h0, done}, {31'h0, e_done});
      check("bus_err", {31'h0, bus_err}, {31'h0, e_buserr});
      check("mem_req", {31'h0, mem_req}, {31'h0, e_req});
      if (e_done) check("rdata", rdata, e_rdata);
      if (e_req) begin
        check("mem_we", {31'h0, mem_we}, {31'h0, e_we});
        check("mem_addr", mem_addr, e_addr);
        check("mem_be", {28'h0, mem_be}, {28'h0, e_be});
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // One access; start is held through REQ and DONE as a stalled datapath would.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int waits,
                        input bit stuck, output logic [31:0] got_rdata,
                        output logic [3:0] got_be, output logic [31:0] got_wdata,
                        output logic got_fault);
    bit rej;
    got_rdata = 0; got_be = 0; got_wdata = 0;
    @(posedge clk); #1;
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    rej = m_reject(st, f3, a);
    mem_ready = rej;  // a stray ready while idle must be ignored
    idle_exp(); e_stall = !rej; e_fault = rej;
    @(negedge clk);
    got_fault = fault;
    if (!rej) begin
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        idle_exp(); e_req = 1; e_stall = 1; e_we = st; e_addr = a & ~32'h3;
        e_be = m_be(st, f3, a); e_wdata = m_lane(f3, wd);
        mem_ready = !stuck && (i == waits);
        mem_rdata = mem_ready ? word : 32'h5A5A_5A5A;
        @(negedge clk);
        if (i == 0) begin got_be = mem_be; got_wdata = mem_wdata; end
        if (mem_ready || (stuck && i == TMO - 1)) break;
        if (i == 299) check("req_bound", 32'(i), 32'(waits));
      end
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = 32'h0;
      idle_exp(); e_done = 1; e_buserr = stuck;
      e_rdata = (st || stuck) ? 32'h0 : m_load(f3, a, word);
      @(negedge clk);
      got_rdata = rdata;
    end
    @(posedge clk); #1;
    start = 0; mem_ready = 0;
    idle_exp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, w;
    logic [3:0]  b;
    logic        f;
    idle_exp();
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);

    access(1, F3_W, 32'h104, 32'hDEADBEEF, 0, 0, 0, r, b, w, f);
    check("sw_be_lit", {28'h0, b}, 32'hF);
    check("sw_rdata_lit", r, 32'h0);
    access(0, F3_B, 32'h203, 0, 32'h80112233, 3, 0, r, b, w, f);
    check("lb_lit", r, 32'hFFFFFF80);
    access(0, F3_BU, 32'h203, 0, 32'h80112233, 3, 0, r, b, w, f);
    check("lbu_lit", r, 32'h00000080);
    access(1, F3_H, 32'h0A, 32'h0000ABCD, 0, 1, 0, r, b, w, f);
    check("sh_be_lit", {28'h0, b}, 32'hC);
    check("sh_wdata_lit", w, 32'hABCDABCD);
    access(0, F3_H, 32'h202, 0, 32'h80112233, 0, 0, r, b, w, f);
    check("lh_lit", r, 32'hFFFF8011);
    access(0, F3_HU, 32'h202, 0, 32'h80112233, 2, 0, r, b, w, f);
    check("lhu_lit", r, 32'h00008011);
    access(0, F3_W, 32'h200, 0, 32'h80112233, 1, 0, r, b, w, f);
    check("lw_lit", r, 32'h80112233);
    access(1, F3_B, 32'h301, 32'h123456A5, 0, 0, 0, r, b, w, f);
    check("sb_be_lit", {28'h0, b}, 32'h2);
    check("sb_wdata_lit", w, 32'hA5A5A5A5);

    access(0, F3_W, 32'h06, 0, 0, 0, 0, r, b, w, f);
    check("lw_mis_fault_lit", {31'h0, f}, 32'h1);
    access(0, F3_H, 32'h05, 0, 0, 0, 0, r, b, w, f);
    check("lh_mis_fault_lit", {31'h0, f}, 32'h1);
    access(0, 3'b011, 32'h08, 0, 0, 0, 0, r, b, w, f);
    check("ld011_fault_lit", {31'h0, f}, 32'h1);
    access(1, F3_BU, 32'h08, 32'h1, 0, 0, 0, r, b, w, f);
    check("sbu_fault_lit", {31'h0, f}, 32'h1);

    // Reset while wait-stated in REQ: no done pulse, then a clean store.
    @(posedge clk); #1;
    start = 1; is_store = 0; funct3 = F3_W; addr = 32'h10;
    idle_exp(); e_stall = 1;
    @(negedge clk);
    @(posedge clk); #1;
    idle_exp(); e_req = 1; e_stall = 1; e_addr = 32'h10; e_be = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0; mem_ready = 1; mem_rdata = 32'h11223344;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1; start = 0; mem_ready = 0;
    idle_exp();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    access(1, F3_W, 32'h40, 32'hCAFEF00D, 0, 0, 0, r, b, w, f);
    check("post_rst_sw_wdata_lit", w, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
    access(0, F3_W, 32'h20, 0, 0, 0, 1, r, b, w, f);
    check("timeout_rdata_lit", r, 32'h0);
`endif

    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the datapath ALU. Replaces the ideal single-cycle data memory path.
- Takes the ALU address, rs2 store data and funct3 from the datapath.
- Drives a word-addressed memory bus with byte enables and a req/ready handshake.
- Returns sign/zero-extended load data, and stalls the datapath (PC and register write) while an access is in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ready before aborting; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at rising edge resets).
- start  in  1  current instruction is a load/store.
- is_store  in  1  1=store, 0=load.
- funct3  in  3  instruction funct3.
- addr  in  ADDR_W  byte address from ALU.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; valid while done=1.
- done  out  1  one-cycle access-complete pulse.
- stall  out  1  hold PC and block regWrite.
- fault  out  1  misaligned or illegal-funct3 access rejected.
- bus_err  out  1  access aborted by timeout (0 when feature off).
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_ready  in  1  bus accepts/completes the request.
- mem_rdata  in  32  bus read word, valid with mem_ready.

Behaviour:
- Reset values: all outputs 0; state=IDLE; captured registers cleared.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = start & ~reject.
  - fault = start & reject (combinational, no memory access, stall=0).
  - On start & ~reject: capture word address, be, wdata and funct3; go to REQ.
- reject conditions:
  - funct3 ∈ {011,110,111} for loads.
  - funct3 ∉ {000,001,010} for stores.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠00.
- REQ:
  - mem_req=1, stall=1.
  - mem_we, mem_addr, mem_be and mem_wdata come from registers and are held stable until mem_ready.
  - On mem_ready=1: capture the extended load data (loads only) and go to DONE.
  - Minimum latency: start at cycle N → mem_req at N+1 → done at N+2 with zero-wait memory.
- DONE:
  - done=1, stall=0, rdata valid; always go to IDLE next cycle.
  - start is ignored in DONE; the datapath advances on this edge.
- Byte enables:
  - SB: be = 0001<<addr[1:0], wdata[7:0] replicated to all 4 lanes.
  - SH: be = 0011<<addr[1:0], wdata[15:0] replicated to both halves.
  - SW: be = 1111.
  - Loads: mem_be = 1111.
- Load extension, by lane addr[1:0]:
  - LB 000: sign-extend the byte.
  - LBU 100: zero-extend the byte.
  - LH 001: sign-extend the half.
  - LHU 101: zero-extend the half.
  - LW 010: full word.
- Store: rdata=0 in DONE.
- mem_ready while mem_req=0: ignored.
- Reset low in REQ or DONE: IDLE next edge; mem_req and done drop; no done pulse.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to DONE with bus_err=1 and rdata=0 for that one cycle.
  - If mem_ready arrives on the same cycle the counter reaches TIMEOUT_CYCLES, mem_ready wins (normal completion).
- Undefined: no counter, bus_err tied 0, REQ waits indefinitely.

Decomposition:
- Package riscv_lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - lsu_state_t enum {IDLE, REQ, DONE}.
  - Default TIMEOUT_CYCLES.
- Sub-module lsu_align: combinational store-lane steering/be generation and load extraction/extension. The FSM and registers stay in riscv_lsu.

Test Plan:
- SW addr=0x104 wdata=0xDEADBEEF, mem_ready=1 immediately → mem_req cycle N+1 with mem_addr=0x104, be=1111, mem_we=1; done at N+2; stall high for N and N+1 only.
- LB addr=0x203, mem_rdata=0x80112233, ready after 3 wait cycles → mem_req held stable 4 cycles, then rdata=0xFFFFFF80; LBU same access → 0x00000080.
- SH addr=0x0A wdata=0x0000ABCD → be=1100, mem_wdata=0xABCDABCD, mem_addr=0x08.
- LW addr=0x06, then LH addr=0x05, then load funct3=011 → fault=1 the same cycle for each, mem_req never asserted, stall=0.
- rst=0 during REQ (wait-stated) → next edge mem_req=0, no done pulse; a new SW after reset completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck 0 → mem_req high 4 cycles, then done=1 and bus_err=1 for one cycle, then IDLE.
